// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
//
// Purpose:
//   Unsigned restoring division. After a start is accepted the divider
//   iterates WIDTH times, then presents quotient/remainder for one DONE
//   cycle. A zero divisor finishes immediately with quotient = all ones,
//   remainder = dividend and div_by_zero set.
//
// Ports (seq_divider):
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   request a division (accepted in IDLE or DONE)
//   dividend     in   WIDTH  unsigned dividend, sampled with accepted start
//   divisor      in   WIDTH  unsigned divisor, sampled with accepted start
//   busy         out  high while iterating
//   done         out  single-cycle result-valid pulse
//   quotient     out  WIDTH  registered quotient
//   remainder    out  WIDTH  registered remainder
//   div_by_zero  out  last accepted operation had divisor == 0
//
// Ports (sub):
//   a_i     in   W  minuend
//   b_i     in   W  subtrahend
//   diff_o  out  W  a_i - b_i (modulo 2^W)
//   cout_o  out  1 when no borrow (a_i >= b_i)

module sub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         cout_o
);

    // a + ~b + 1: the carry out of the top bit is the "no borrow" flag.
    assign {cout_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};

endmodule

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend shifts out the top, quotient bits enter the bottom
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;      // partial remainder R
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;      // output registers, separate from the working set
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic             accept;
    logic             qbit;
    logic             rem_msb_unused;

    // R' can exceed 2^WIDTH, so the trial subtraction is WIDTH+1 bits wide.
    assign shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

    sub #(.W(WIDTH + 1)) u_sub (
        .a_i    (shifted),
        .b_i    ({1'b0, dvs_q}),
        .diff_o (diff),
        .cout_o (no_borrow)
    );

    // R stays below the divisor after every iteration, so its MSB is never
    // fed back into the next shift.
    assign rem_msb_unused = rem_q[WIDTH];

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign qbit   = no_borrow;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_RUN: begin
                rem_d = qbit ? diff : shifted;
                dvd_d = {dvd_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    quo_d   = {dvd_q[WIDTH-2:0], qbit};
                    remo_d  = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Only possible in IDLE or DONE, so it never collides with RUN updates.
        if (accept) begin
            dvd_d = dividend;
            dvs_d = divisor;
            rem_d = '0;
            cnt_d = '0;
            if (divisor != '0) begin
                state_d = S_RUN;
            end else begin
                state_d = S_DONE;
                quo_d   = '1;
                remo_d  = dividend;
                dbz_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule
